// File: rtl/ir_pkg.sv
// Shared IR definitions: function-select codes, half-select codes and the
// fetch sequencer state encoding.
package ir_pkg;

   localparam logic [1:0] IR_FUNSEL_CLR  = 2'b00;
   localparam logic [1:0] IR_FUNSEL_LOAD = 2'b01;
   localparam logic [1:0] IR_FUNSEL_DEC  = 2'b10;
   localparam logic [1:0] IR_FUNSEL_INC  = 2'b11;

   localparam logic IR_HALF_LO = 1'b0;
   localparam logic IR_HALF_HI = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_RD_LO = 3'd2,
      ST_LD_LO = 3'd3,
      ST_RD_HI = 3'd4,
      ST_LD_HI = 3'd5,
      ST_VALID = 3'd6
   } fetch_state_t;

endpackage

// File: rtl/ir_fetch_ctrl.sv
// Instruction fetch sequencer: reads two bytes at PC, loads the 16-bit IR in
// halves and offers it to the decoder. Optional mem_ack timeout: FETCH_TIMEOUT_EN.
module ir_fetch_ctrl
   import ir_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_val,
   output logic [ADDR_W-1:0] pc,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic              ir_e,
   output logic [1:0]        ir_funsel,
   output logic              ir_l_h,
   output logic [7:0]        ir_byte,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              fetch_err
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] w_pc_inc1;
   logic [7:0]        r_data;
   logic [7:0]        w_data_nxt;
   logic              w_timeout;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("ir_fetch_ctrl: TIMEOUT must be at least 1");
   end

   assign w_pc_inc1 = r_pc + ADDR_W'(1);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_data  <= w_data_nxt;
      end
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_data_nxt  = r_data;
      case (r_state)
         ST_IDLE:  if (fetch_req) w_state_nxt = ST_CLR;
         ST_CLR:   w_state_nxt = ST_RD_LO;
         ST_RD_LO: begin
            if (mem_ack) begin
               w_data_nxt  = mem_rdata;
               w_state_nxt = ST_LD_LO;
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LD_LO: w_state_nxt = ST_RD_HI;
         ST_RD_HI: begin
            if (mem_ack) begin
               w_data_nxt  = mem_rdata;
               w_state_nxt = ST_LD_HI;
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LD_HI: w_state_nxt = ST_VALID;
         ST_VALID: begin
            if (instr_ready) begin
               w_pc_nxt    = r_pc + ADDR_W'(2);
               w_state_nxt = fetch_req ? ST_CLR : ST_IDLE;
            end
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
      // A PC load aborts the fetch; a half-written IR is cleared by the next fetch.
      if (pc_load) begin
         w_state_nxt = ST_IDLE;
         w_pc_nxt    = pc_load_val;
         w_data_nxt  = r_data;
      end
   end

   always_comb begin
      mem_rd      = 1'b0;
      mem_addr    = '0;
      ir_e        = 1'b0;
      ir_funsel   = IR_FUNSEL_CLR;
      ir_l_h      = IR_HALF_LO;
      ir_byte     = 8'h00;
      instr_valid = 1'b0;
      case (r_state)
         ST_CLR:   ir_e = 1'b1;
         ST_RD_LO: begin
            mem_rd   = 1'b1;
            mem_addr = r_pc;
         end
         ST_LD_LO: begin
            ir_e      = 1'b1;
            ir_funsel = IR_FUNSEL_LOAD;
            ir_byte   = r_data;
         end
         ST_RD_HI: begin
            mem_rd   = 1'b1;
            mem_addr = w_pc_inc1;
         end
         ST_LD_HI: begin
            ir_e      = 1'b1;
            ir_funsel = IR_FUNSEL_LOAD;
            ir_l_h    = IR_HALF_HI;
            ir_byte   = r_data;
         end
         ST_VALID: instr_valid = 1'b1;
         default:  ;
      endcase
   end

   assign pc = r_pc;

`ifdef FETCH_TIMEOUT_EN
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_err;
   logic              w_in_rd;

   assign w_in_rd   = (r_state == ST_RD_LO) || (r_state == ST_RD_HI);
   assign w_timeout = w_in_rd && !mem_ack && (r_wait_cnt == WAIT_W'(TIMEOUT - 1));

   // Counter is zero outside the read states, so it starts clean on every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_timeout && !pc_load;
         if (w_in_rd && !mem_ack && !w_timeout && !pc_load)
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         else
            r_wait_cnt <= '0;
      end
   end

   assign fetch_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Self-checking bench for ir_fetch_ctrl with a byte memory model and an
// IR_16_bit stand-in; expected words come from the memory array and PC model.
module tb_ir_fetch_ctrl;
   import ir_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req, pc_load, instr_ready;
   logic [15:0] pc_load_val, pc, mem_addr;
   logic        mem_rd, mem_ack, ir_e, ir_l_h, instr_valid, fetch_err;
   logic [7:0]  mem_rdata, ir_byte;
   logic [1:0]  ir_funsel;

   logic [7:0]  mem [0:65535];
   int          mem_lat;
   logic        mem_stuck;
   int          wait_cnt;
   logic [15:0] ir_q;
   int          clr_cnt;
   logic [15:0] model_pc;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   ir_fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_load(pc_load),
      .pc_load_val(pc_load_val), .pc(pc), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir_e(ir_e), .ir_funsel(ir_funsel),
      .ir_l_h(ir_l_h), .ir_byte(ir_byte), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .fetch_err(fetch_err)
   );

   // Byte memory: ack after mem_lat wait cycles (0 = same cycle as mem_rd).
   assign mem_ack   = mem_rd && !mem_stuck && (wait_cnt >= mem_lat);
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_rd && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                    wait_cnt <= 0;
   end

   // IR_16_bit stand-in.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q <= 16'h0000;
      end else if (ir_e) begin
         case (ir_funsel)
            2'b00: begin
               ir_q    <= 16'h0000;
               clr_cnt <= clr_cnt + 1;
            end
            2'b01: if (ir_l_h) ir_q[15:8] <= ir_byte; else ir_q[7:0] <= ir_byte;
            2'b10: ir_q <= ir_q - 16'd1;
            default: ir_q <= ir_q + 16'd1;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else             n_pass++;
   endtask

   function automatic logic [15:0] exp_word(input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return {mem[a1], mem[a]};
   endfunction

   task automatic load_pc(input logic [15:0] v);
      @(negedge clk);
      pc_load = 1'b1;
      pc_load_val = v;
      @(negedge clk);
      pc_load = 1'b0;
      model_pc = v;
   endtask

   // Pulse fetch_req from IDLE and wait for instr_valid; returns at that negedge.
   task automatic fetch_wait(input int exp_lat, input string tag);
      int n;
      int clr0;
      n = 0;
      @(negedge clk);
      fetch_req = 1'b1;
      clr0 = clr_cnt;
      @(negedge clk);
      fetch_req = 1'b0;
      while (!instr_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_ir"}, ir_q, exp_word(model_pc));
      check({tag, "_clr"}, clr_cnt - clr0, 1);
      check({tag, "_pchold"}, pc, model_pc);
   endtask

   task automatic handshake(input string tag);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      model_pc = model_pc + 16'd2;
      check({tag, "_pc"}, pc, model_pc);
      check({tag, "_vld_drop"}, instr_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hs;
      logic seen;
      logic [15:0] v;
      int lat;
      rst_n = 1'b0;
      fetch_req = 1'b0;
      pc_load = 1'b0;
      pc_load_val = 16'h0000;
      instr_ready = 1'b0;
      mem_lat = 0;
      mem_stuck = 1'b0;
      wait_cnt = 0;
      clr_cnt = 0;
      model_pc = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

      #23;
      check("rst_pc", pc, 16'h0000);
      check("rst_outs", {mem_rd, mem_addr, ir_e, ir_funsel, ir_l_h, ir_byte, instr_valid, fetch_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic fetch, zero-wait.
      mem[16'h0010] = 8'hAA;
      mem[16'h0011] = 8'h33;
      load_pc(16'h0010);
      fetch_wait(5, "basic");
      check("basic_word", ir_q, 16'h33AA);
      handshake("basic");

      // Back-to-back with fetch_req and instr_ready held.
      mem[16'h0012] = 8'h4C;
      mem[16'h0013] = 8'h4C;
      mem[16'h0014] = 8'h55;
      mem[16'h0015] = 8'h66;
      @(negedge clk);
      fetch_req = 1'b1;
      instr_ready = 1'b1;
      hs = 0;
      n = 0;
      while (hs < 2 && n < 60) begin
         @(negedge clk);
         n++;
         if (instr_valid) begin
            hs++;
            if (hs == 1) begin
               check("b2b_ir0", ir_q, exp_word(16'h0012));
               @(negedge clk);
               n++;
               check("b2b_noidle", {ir_e, ir_funsel}, {1'b1, IR_FUNSEL_CLR});
            end else begin
               check("b2b_ir1", ir_q, exp_word(16'h0014));
               fetch_req = 1'b0;
               @(negedge clk);
               instr_ready = 1'b0;
            end
         end
      end
      check("b2b_count", hs, 2);
      model_pc = model_pc + 16'd4;
      check("b2b_pc", pc, model_pc);

      // Three wait cycles per byte.
      mem[16'h0016] = 8'h9E;
      mem[16'h0017] = 8'h71;
      mem_lat = 3;
      fetch_wait(11, "slow");
      handshake("slow");
      mem_lat = 0;

      // PC wrap-around.
      mem[16'hFFFF] = 8'hF0;
      mem[16'h0000] = 8'h01;
      load_pc(16'hFFFF);
      fetch_wait(5, "wrap");
      check("wrap_word", ir_q, 16'h01F0);
      handshake("wrap");

      // pc_load during RD_HI while mem_ack is high.
      mem[16'h0020] = 8'h11;
      mem[16'h0021] = 8'h22;
      mem[16'h0040] = 8'h5A;
      mem[16'h0041] = 8'hA5;
      load_pc(16'h0020);
      @(negedge clk);
      fetch_req = 1'b1;
      @(negedge clk);
      fetch_req = 1'b0;
      n = 0;
      while (!(mem_rd && mem_addr == 16'h0021) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("abort_rdhi", {mem_rd, mem_ack, mem_addr}, {1'b1, 1'b1, 16'h0021});
      pc_load = 1'b1;
      pc_load_val = 16'h0040;
      @(negedge clk);
      pc_load = 1'b0;
      model_pc = 16'h0040;
      check("abort_pc", pc, 16'h0040);
      check("abort_idle", {mem_rd, ir_e, instr_valid}, 0);
      check("abort_partial", ir_q, {8'h00, mem[16'h0020]});
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (instr_valid) seen = 1'b1;
      end
      check("abort_novalid", seen, 0);
      fetch_wait(5, "after_abort");
      handshake("after_abort");

      // pc_load coincident with the handshake.
      fetch_wait(5, "ldhs");
      instr_ready = 1'b1;
      pc_load = 1'b1;
      pc_load_val = 16'h0100;
      @(negedge clk);
      instr_ready = 1'b0;
      pc_load = 1'b0;
      model_pc = 16'h0100;
      check("ldhs_pc", pc, 16'h0100);
      check("ldhs_vld", instr_valid, 0);

      // Randomized fetches.
      for (int i = 0; i < 10; i++) begin
         v = 16'($urandom);
         lat = int'($urandom_range(0, 3));
         mem[v] = 8'($urandom);
         mem[16'(v + 16'd1)] = 8'($urandom);
         load_pc(v);
         mem_lat = lat;
         fetch_wait(5 + 2 * lat, $sformatf("rnd%0d", i));
         handshake($sformatf("rnd%0d", i));
      end
      mem_lat = 0;

`ifdef FETCH_TIMEOUT_EN
      mem_stuck = 1'b1;
      @(negedge clk);
      fetch_req = 1'b1;
      @(negedge clk);
      fetch_req = 1'b0;
      n = 0;
      while (!fetch_err && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("to_lat", n, 16);
      check("to_rd", mem_rd, 0);
      check("to_pc", pc, model_pc);
      @(negedge clk);
      check("to_pulse", fetch_err, 0);
      mem_stuck = 1'b0;
`else
      check("no_err", fetch_err, 0);
`endif

      // Asynchronous reset in the middle of a read.
      mem_lat = 3;
      load_pc(16'h0300);
      @(negedge clk);
      fetch_req = 1'b1;
      @(negedge clk);
      fetch_req = 1'b0;
      n = 0;
      while (!mem_rd && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("mid_rd", mem_rd, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_rd", mem_rd, 0);
      check("mid_rst_pc", pc, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      mem_lat = 0;
      model_pc = 16'h0000;
      fetch_wait(5, "post_rst");
      handshake("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
